psram_frame_reader: RTL and testbench

PSRAM_FRAME_READER -- requirements
Module: psram_frame_reader

---
 rtl/PSRAM_Utilities.sv | 28 ++
 rtl/psram_frame_reader.sv | 195 +++++++++++++++++++
 tb/tb_psram_frame_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/PSRAM_Utilities.sv
// Shared PSRAM helpers: command encodings, reader state type and burst timing
// derived from the controller's burst length.
package PSRAM_Utilities;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    ISSUE,
    WAIT_DATA,
    RECEIVE,
    GAP,
    DONE
  } reader_state_e;

  // Data beats on the 64-bit user bus for one burst (16/32/64/128 -> 4/8/16/32).
  function automatic int burst_cycles(input int burst);
    return burst / 4;
  endfunction

  // Minimum cmd_en-to-cmd_en spacing in clk_out cycles (32 -> 19).
  function automatic int burst_delay(input int burst);
    return burst_cycles(burst) + 11;
  endfunction

endpackage

// File: rtl/psram_frame_reader.sv
// Streams a frame of fixed-length PSRAM read bursts into a downstream FIFO,
// issuing a burst only when the FIFO can absorb all of its beats.
module psram_frame_reader
  import PSRAM_Utilities::*;
#(
  parameter int MEMORY_BURST = 32,
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 64,
  parameter int FRAME_BURSTS = 4800
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_calib,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  cmd,
  output logic                  cmd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  input  logic [7:0]            fifo_free,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int N     = burst_cycles(MEMORY_BURST);
  localparam int D     = burst_delay(MEMORY_BURST);
  localparam int DLY_W = 8;
  localparam int BEAT_W = 8;
  localparam int IDX_W = $clog2(FRAME_BURSTS + 1);

  localparam logic [DLY_W-1:0]      TIMEOUT    = DLY_W'(2 * D);
  // WAIT_SPACE and ISSUE add two cycles before the next cmd_en becomes visible.
  localparam logic [DLY_W-1:0]      GAP_END    = DLY_W'(D - 2);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(N - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(FRAME_BURSTS);
  localparam logic [7:0]            MIN_FREE   = 8'(N);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(MEMORY_BURST);

  reader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  stale_q, stale_d;
  logic                  calib_lost_q, calib_lost_d;
  logic                  cmd_en_q, cmd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  in_window;
  logic                  abort;

  assign idx_next  = idx_q + IDX_W'(1);
  assign in_window = (state_q == WAIT_DATA) || (state_q == RECEIVE);
  assign abort     = calib_lost_q || !init_calib;

  // NOTE: every *_d gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    idx_d        = idx_q;
    dly_d        = (dly_q != '1) ? dly_q + DLY_W'(1) : dly_q;
    beat_d       = beat_q;
    stale_d      = stale_q;
    calib_lost_d = calib_lost_q || !init_calib;
    cmd_en_d     = 1'b0;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    error_d      = error_q;

    // Beats from an aborted burst may still trickle in after reset.
    if (rd_data_valid) begin
      if (in_window) begin
        wr_en_d   = 1'b1;
        wr_data_d = rd_data;
      end else if (!stale_q) begin
        error_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        calib_lost_d = 1'b0;
        if (start && init_calib) begin
          burst_addr_d = base_addr;
          idx_d        = '0;
          state_d      = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (abort) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (fifo_free >= MIN_FREE) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_en_d = 1'b1;
        addr_d   = burst_addr_q;
        dly_d    = DLY_W'(1);
        beat_d   = '0;
        stale_d  = 1'b0;
        state_d  = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rd_data_valid) begin
          beat_d  = BEAT_W'(1);
          state_d = RECEIVE;
        end else if (dly_q == TIMEOUT) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      RECEIVE: begin
        if (rd_data_valid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = GAP;
        end
      end
      GAP: begin
        if (dly_q >= GAP_END) begin
          idx_d        = idx_next;
          burst_addr_d = burst_addr_q + BURST_STEP;
          if (abort) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else if (idx_next == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      idx_q        <= '0;
      dly_q        <= '0;
      beat_q       <= '0;
      stale_q      <= 1'b1;
      calib_lost_q <= 1'b0;
      cmd_en_q     <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      idx_q        <= idx_d;
      dly_q        <= dly_d;
      beat_q       <= beat_d;
      stale_q      <= stale_d;
      calib_lost_q <= calib_lost_d;
      cmd_en_q     <= cmd_en_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign cmd          = CMD_READ;
  assign cmd_en       = cmd_en_q;
  assign addr         = addr_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_psram_frame_reader.sv
// Directed bench: two reader instances (burst 32 and burst 16), each fed by a
// PSRAM model that answers cmd_en with a configurable number of beats.
module tb_psram_frame_reader;

  localparam int AW  = 21;
  localparam int DW  = 64;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset, init_calib;
  logic [7:0]    fifo_free;

  logic          start, cmd, cmd_en, rd_data_valid, fifo_wr_en, busy, done, error;
  logic [AW-1:0] base_addr, addr;
  logic [DW-1:0] rd_data, fifo_wr_data;

  logic          start_b, cmd_b, cmd_en_b, rd_valid_b, wr_en_b, busy_b, done_b, error_b;
  logic [AW-1:0] base_b, addr_b;
  logic [DW-1:0] rd_data_b, wr_data_b;

  always #5 clk = ~clk;

  psram_frame_reader #(.MEMORY_BURST(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BURSTS(2)) dut_a (
    .clk(clk), .reset(reset), .init_calib(init_calib), .start(start), .base_addr(base_addr),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .fifo_free(fifo_free), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .done(done), .error(error)
  );

  psram_frame_reader #(.MEMORY_BURST(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_BURSTS(2)) dut_b (
    .clk(clk), .reset(reset), .init_calib(init_calib), .start(start_b), .base_addr(base_b),
    .cmd(cmd_b), .cmd_en(cmd_en_b), .addr(addr_b), .rd_data(rd_data_b), .rd_data_valid(rd_valid_b),
    .fifo_free(fifo_free), .fifo_wr_en(wr_en_b), .fifo_wr_data(wr_data_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PSRAM models: beat k of a burst is returned LAT+k cycles after cmd_en.
  int since_a = 255, since_b = 255;
  int beats_a = 8,   beats_b = 4;

  always @(negedge clk) begin
    if (cmd_en) since_a = 0; else if (since_a < 255) since_a++;
    rd_data_valid = (since_a >= LAT) && (since_a < LAT + beats_a);
    rd_data       = 64'hC0DE_0000_0000_0000 | 64'(since_a);
    if (cmd_en_b) since_b = 0; else if (since_b < 255) since_b++;
    rd_valid_b = (since_b >= LAT) && (since_b < LAT + beats_b);
    rd_data_b  = 64'hB000_0000_0000_0000 | 64'(since_b);
  end

  // Observation of DUT outputs, one sample per cycle on the falling edge.
  int            cyc = 0;
  int            wr_cnt, done_cnt, done_cyc, done_cnt_b;
  logic [DW-1:0] wr_first, wr_last;
  int            cmd_cyc[$], cmd_cyc_b[$];
  logic [AW-1:0] cmd_addr[$], cmd_addr_b[$];

  always @(negedge clk) begin
    cyc++;
    if (cmd_en === 1'b1) begin cmd_cyc.push_back(cyc); cmd_addr.push_back(addr); end
    if (fifo_wr_en === 1'b1) begin
      if (wr_cnt == 0) wr_first = fifo_wr_data;
      wr_last = fifo_wr_data;
      wr_cnt++;
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (cmd_en_b === 1'b1) begin cmd_cyc_b.push_back(cyc); cmd_addr_b.push_back(addr_b); end
    if (done_b === 1'b1) done_cnt_b++;
  end

  function automatic int cyc_at(input int i);
    return (i < cmd_cyc.size()) ? cmd_cyc[i] : -1000;
  endfunction

  function automatic logic [63:0] addr_at(input int i, input logic sel_b);
    if (sel_b) return (i < cmd_addr_b.size()) ? 64'(cmd_addr_b[i]) : 64'hDEAD;
    return (i < cmd_addr.size()) ? 64'(cmd_addr[i]) : 64'hDEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; done_cyc = 0; done_cnt_b = 0;
    wr_first = '0; wr_last = '0;
    cmd_cyc.delete(); cmd_addr.delete(); cmd_cyc_b.delete(); cmd_addr_b.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    clear_mon();
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic sel_b);
    int n = 0;
    while (((sel_b ? done_cnt_b : done_cnt) == 0) && n < budget) begin tick(1); n++; end
    check({tag, "_done_seen"}, 64'((sel_b ? done_cnt_b : done_cnt) != 0), 64'd1);
  endtask

  // Returns in the cycle where cmd_en is visible (t = 0 of the burst).
  task automatic wait_cmd(input string tag, input int budget);
    int n = 0;
    while (cmd_cyc.size() == 0 && n < budget) begin tick(1); n++; end
    check({tag, "_cmd_seen"}, 64'(cmd_cyc.size()), 64'd1);
  endtask

  int w0;

  initial begin
    reset = 1'b1; init_calib = 1'b0; fifo_free = 8'd0;
    start = 1'b0; base_addr = '0; start_b = 1'b0; base_b = '0;
    tick(3);
    check("rst_cmd",     64'(cmd),          64'd0);
    check("rst_cmd_en",  64'(cmd_en),       64'd0);
    check("rst_addr",    64'(addr),         64'd0);
    check("rst_wr_en",   64'(fifo_wr_en),   64'd0);
    check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    check("rst_busy",    64'(busy),         64'd0);
    check("rst_done",    64'(done),         64'd0);
    check("rst_error",   64'(error),        64'd0);

    // Two-burst frame at 0x100, with a stray start mid-frame that must be ignored.
    reset = 1'b0; init_calib = 1'b1; fifo_free = 8'd200; beats_a = 8;
    tick(1);
    clear_mon();
    pulse_start(21'h100);
    check("frame_busy", 64'(busy), 64'd1);
    tick(8);
    pulse_start(21'h555);
    wait_done("frame", 200, 1'b0);
    check("frame_cmds",     64'(cmd_cyc.size()),       64'd2);
    check("frame_addr0",    addr_at(0, 1'b0),          64'h100);
    check("frame_addr1",    addr_at(1, 1'b0),          64'h120);
    check("frame_cmd_gap",  64'(cyc_at(1) - cyc_at(0)), 64'd19);
    check("frame_done_lat", 64'(done_cyc - cyc_at(1)), 64'd17);
    check("frame_writes",   64'(wr_cnt),               64'd16);
    check("frame_first",    wr_first,                  64'hC0DE_0000_0000_0005);
    check("frame_last",     wr_last,                   64'hC0DE_0000_0000_000C);
    tick(2);
    check("frame_done_len", 64'(done_cnt), 64'd1);
    check("frame_idle",     64'(busy),     64'd0);
    check("frame_error",    64'(error),    64'd0);

    // Insufficient FIFO space holds the burst back.
    do_reset();
    fifo_free = 8'd7;
    pulse_start(21'h200);
    tick(20);
    check("space_no_cmd", 64'(cmd_cyc.size()), 64'd0);
    check("space_busy",   64'(busy),           64'd1);
    fifo_free = 8'd8;
    tick(1);
    check("space_cmd_c1", 64'(cmd_en), 64'd0);
    tick(1);
    check("space_cmd_c2", 64'(cmd_en), 64'd1);
    wait_done("space", 200, 1'b0);

    // No data ever returned: timeout after 2*D cycles.
    do_reset();
    fifo_free = 8'd200; beats_a = 0;
    pulse_start(21'h300);
    wait_cmd("timeout", 50);
    tick(37);
    check("timeout_early", 64'(error), 64'd0);
    tick(1);
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_busy",  64'(busy),  64'd0);

    // Nine beats: the surplus beat is dropped and flagged.
    do_reset();
    beats_a = 9;
    pulse_start(21'h400);
    wait_cmd("extra", 50);
    tick(16);
    check("extra_writes", 64'(wr_cnt), 64'd8);
    check("extra_error",  64'(error),  64'd1);
    wait_done("extra", 200, 1'b0);
    check("extra_writes_all", 64'(wr_cnt), 64'd16);

    // Start without calibration is ignored.
    do_reset();
    beats_a = 8; init_calib = 1'b0;
    pulse_start(21'h500);
    tick(5);
    check("nocal_busy", 64'(busy),           64'd0);
    check("nocal_cmds", 64'(cmd_cyc.size()), 64'd0);

    // Reset in the middle of RECEIVE; trailing beats must not raise error.
    init_calib = 1'b1;
    pulse_start(21'h600);
    wait_cmd("abort", 50);
    tick(7);
    check("abort_pre_wr", 64'(fifo_wr_en), 64'd1);
    reset = 1'b1;
    tick(1);
    check("abort_cmd_en",  64'(cmd_en),       64'd0);
    check("abort_addr",    64'(addr),         64'd0);
    check("abort_wr_en",   64'(fifo_wr_en),   64'd0);
    check("abort_wr_data", 64'(fifo_wr_data), 64'd0);
    check("abort_busy",    64'(busy),         64'd0);
    check("abort_done",    64'(done),         64'd0);
    check("abort_error",   64'(error),        64'd0);
    reset = 1'b0;
    w0 = wr_cnt;
    tick(12);
    check("stale_error",  64'(error),  64'd0);
    check("stale_writes", 64'(wr_cnt), 64'(w0));

    // Calibration glitch mid-burst: burst completes, then the frame aborts.
    clear_mon();
    pulse_start(21'h700);
    wait_cmd("calib", 50);
    tick(2);
    init_calib = 1'b0;
    tick(1);
    init_calib = 1'b1;
    tick(22);
    check("calib_busy",   64'(busy),           64'd0);
    check("calib_error",  64'(error),          64'd1);
    check("calib_writes", 64'(wr_cnt),         64'd8);
    check("calib_cmds",   64'(cmd_cyc.size()), 64'd1);

    // Burst-16 instance: address wraps past the top of the address space.
    do_reset();
    base_b  = 21'h1FFFF0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done("wrap", 200, 1'b1);
    check("wrap_addr0", addr_at(0, 1'b1), 64'h1FFFF0);
    check("wrap_addr1", addr_at(1, 1'b1), 64'h000000);
    check("wrap_gap",   64'(((cmd_cyc_b.size() > 1) ? cmd_cyc_b[1] - cmd_cyc_b[0] : -1)), 64'd15);
    check("wrap_error", 64'(error_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
